// File: rtl/tinyml_pkg.sv
// Shared types and defaults for the TinyML tile datapath.
package tinyml_pkg;

    localparam int unsigned TILE_WIDTH_DEFAULT = 256;

    typedef logic [TILE_WIDTH_DEFAULT-1:0] tile_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FINISH  = 2'd2
    } tbuf_state_e;

endpackage

// File: rtl/tile_ram.sv
// 1-write / 1-read synchronous tile RAM; a same-slot read and write returns the old contents.
module tile_ram #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/m_tile_buffer.sv
// Captures loader tiles into sequential slots from a programmable base and serves them on a 1-cycle read port.
module m_tile_buffer
    import tinyml_pkg::*;
#(
    parameter int unsigned TILE_WIDTH = TILE_WIDTH_DEFAULT,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [$clog2(DEPTH)-1:0]  base_slot,
    input  logic                      tile_valid,
    input  logic [TILE_WIDTH-1:0]     tile_data,
    input  logic                      load_done,
    input  logic                      rd_en,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [TILE_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(DEPTH):0]    tile_count,
    output logic                      overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    tbuf_state_e state, next_state;
    logic [AW-1:0] wr_ptr;
    logic          wr_en_c;
    logic          clear_c;
    logic          ovf_set_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FINISH waits for the registered done pulse before returning to IDLE.
    always_comb begin
        next_state = state;
        wr_en_c    = 1'b0;
        clear_c    = 1'b0;
        ovf_set_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear_c    = 1'b1;
                    next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (tile_valid) begin
                    if (tile_count == FULL_COUNT) begin
                        ovf_set_c = 1'b1;
                    end else begin
                        wr_en_c = 1'b1;
                    end
                end
                if (load_done) begin
                    next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (done) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Session pointer, counters and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            tile_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            busy     <= (next_state != ST_IDLE);
            done     <= (state == ST_FINISH) && !done;
            rd_valid <= rd_en;
            if (clear_c) begin
                wr_ptr     <= base_slot;
                tile_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (wr_en_c) begin
                    wr_ptr     <= AW'(wr_ptr + 1'b1);
                    tile_count <= (AW+1)'(tile_count + 1'b1);
                end
                if (ovf_set_c) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    tile_ram #(
        .WIDTH (TILE_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tile_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_c),
        .wr_addr (wr_ptr),
        .wr_data (tile_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
